// File: rtl/acc4_pkg.sv
// Shared constants and state encoding for the m_acc4 operand accumulator.
package acc4_pkg;

   localparam int ACC4_WIDTH = 4;
   localparam int ACC4_COUNT = 4;

   typedef enum logic {
      S_ACC  = 1'b0,
      S_DONE = 1'b1
   } acc4_state_t;

endpackage

// File: rtl/m_add_cout.sv
// WIDTH-bit ripple-carry adder with zero carry-in, exposing the final carry-out.
// Each bit position is a full-adder cell chained through the carry vector.
module m_add_cout #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/m_acc4.sv
// Batch accumulator: sums COUNT operands (or fewer on flush), tracks a sticky
// carry-out flag and presents the result through a valid/ready handshake.
// Optional build macro: ACC4_SAT_EN saturates the accumulator on carry-out
// instead of wrapping.
module m_acc4
   import acc4_pkg::*;
#(
   parameter int WIDTH = ACC4_WIDTH,
   parameter int COUNT = ACC4_COUNT,
   parameter int CW    = $clog2(COUNT + 1)
) (
   input  logic             w_clk,
   input  logic             w_rst,
   input  logic             w_in_valid,
   output logic             w_in_ready,
   input  logic [WIDTH-1:0] w_in_data,
   input  logic             w_flush,
   output logic             w_out_valid,
   input  logic             w_out_ready,
   output logic [WIDTH-1:0] w_out_sum,
   output logic             w_out_ovf,
   output logic [CW-1:0]    w_out_cnt
);

   acc4_state_t      state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic             cnt_last;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   assign accept   = w_in_valid & (state_q == S_ACC);
   assign cnt_last = (cnt_q == CW'(COUNT - 1));
   // Gate the operand so an undriven bus never reaches the adder.
   assign add_b    = accept ? w_in_data : '0;

   m_add_cout #(
      .WIDTH (WIDTH)
   ) u_add (
      .a    (acc_q),
      .b    (add_b),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // State register.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state_q <= S_ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: end the batch on the last operand or a non-empty flush.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_ACC: begin
            if ((accept && cnt_last) || (w_flush && ((cnt_q != '0) || accept))) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (w_out_ready) begin
               state_d = S_ACC;
            end
         end
         default: state_d = S_ACC;
      endcase
   end

   // Outputs: handshake flags from state only, result fields show live registers.
   always_comb begin
      w_in_ready  = (state_q == S_ACC);
      w_out_valid = (state_q == S_DONE);
      w_out_sum   = acc_q;
      w_out_ovf   = ovf_q;
      w_out_cnt   = cnt_q;
   end

   // Datapath next values: accumulate on accept, clear after the result is taken.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      cnt_d = cnt_q;
      if ((state_q == S_DONE) && w_out_ready) begin
         acc_d = '0;
         ovf_d = 1'b0;
         cnt_d = '0;
      end else if (accept) begin
`ifdef ACC4_SAT_EN
         // Once saturated, any further nonzero operand carries again, so it stays pinned.
         acc_d = add_cout ? '1 : add_sum;
`else
         acc_d = add_sum;
`endif
         ovf_d = ovf_q | add_cout;
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Datapath registers.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_m_acc4.sv
// Directed bench for m_acc4 with hand-computed expected results.
module tb_m_acc4;

   logic       w_clk;
   logic       w_rst;
   logic       w_in_valid;
   logic       w_in_ready;
   logic [3:0] w_in_data;
   logic       w_flush;
   logic       w_out_valid;
   logic       w_out_ready;
   logic [3:0] w_out_sum;
   logic       w_out_ovf;
   logic [2:0] w_out_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   m_acc4 u_dut (
      .w_clk       (w_clk),
      .w_rst       (w_rst),
      .w_in_valid  (w_in_valid),
      .w_in_ready  (w_in_ready),
      .w_in_data   (w_in_data),
      .w_flush     (w_flush),
      .w_out_valid (w_out_valid),
      .w_out_ready (w_out_ready),
      .w_out_sum   (w_out_sum),
      .w_out_ovf   (w_out_ovf),
      .w_out_cnt   (w_out_cnt)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic vld, input logic rdy,
                            input logic [3:0] sum, input logic ovf, input logic [2:0] cnt);
      check({tag, ".out_valid"}, 32'(w_out_valid), 32'(vld));
      check({tag, ".in_ready"},  32'(w_in_ready),  32'(rdy));
      check({tag, ".sum"},       32'(w_out_sum),   32'(sum));
      check({tag, ".ovf"},       32'(w_out_ovf),   32'(ovf));
      check({tag, ".cnt"},       32'(w_out_cnt),   32'(cnt));
   endtask

   // Advance one clock; outputs are stable 1 time unit after the edge.
   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d);
      w_in_valid = 1'b1;
      w_in_data  = d;
      tick();
      w_in_valid = 1'b0;
      w_in_data  = 'x;
   endtask

   initial begin
      logic [3:0] exp_ovf_sum;
      logic [3:0] exp_99_sum;
`ifdef ACC4_SAT_EN
      exp_ovf_sum = 4'd15;
      exp_99_sum  = 4'd15;
`else
      exp_ovf_sum = 4'd1;
      exp_99_sum  = 4'd2;
`endif
      w_rst       = 1'b1;
      w_in_valid  = 1'b0;
      w_in_data   = 'x;
      w_flush     = 1'b0;
      w_out_ready = 1'b1;
      tick();
      tick();
      check_out("reset", 1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
      w_rst = 1'b0;
      tick();

      // Full batch 3,4,1,2 with consumer ready.
      push(4'd3);
      check_out("b1.live", 1'b0, 1'b1, 4'd3, 1'b0, 3'd1);
      push(4'd4);
      push(4'd1);
      push(4'd2);
      check_out("b1.done", 1'b1, 1'b0, 4'd10, 1'b0, 3'd4);
      tick();
      check_out("b1.clear", 1'b0, 1'b1, 4'd0, 1'b0, 3'd0);

      // Carry-out: 8+9 overflows.
      push(4'd8);
      push(4'd9);
      push(4'd0);
      push(4'd0);
      check_out("ovf.done", 1'b1, 1'b0, exp_ovf_sum, 1'b1, 3'd4);
      tick();

      // Early flush after two operands, then an empty flush.
      push(4'd3);
      push(4'd4);
      w_flush = 1'b1;
      tick();
      w_flush = 1'b0;
      check_out("flush.done", 1'b1, 1'b0, 4'd7, 1'b0, 3'd2);
      tick();
      w_flush = 1'b1;
      tick();
      w_flush = 1'b0;
      check_out("flush.empty", 1'b0, 1'b1, 4'd0, 1'b0, 3'd0);

      // Flush together with a final operand.
      push(4'd1);
      push(4'd1);
      w_flush    = 1'b1;
      w_in_valid = 1'b1;
      w_in_data  = 4'd5;
      tick();
      w_flush    = 1'b0;
      w_in_valid = 1'b0;
      w_in_data  = 'x;
      check_out("flushacc.done", 1'b1, 1'b0, 4'd7, 1'b0, 3'd3);
      tick();

      // Back-pressure: result held, operand 6 not accepted.
      w_out_ready = 1'b0;
      push(4'd1);
      push(4'd2);
      push(4'd3);
      push(4'd4);
      w_in_valid = 1'b1;
      w_in_data  = 4'd6;
      for (int i = 0; i < 3; i++) begin
         check_out("stall", 1'b1, 1'b0, 4'd10, 1'b0, 3'd4);
         tick();
      end
      check_out("stall.end", 1'b1, 1'b0, 4'd10, 1'b0, 3'd4);
      w_in_valid  = 1'b0;
      w_in_data   = 'x;
      w_out_ready = 1'b1;
      tick();
      check_out("stall.clear", 1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
      push(4'd6);
      check_out("stall.next", 1'b0, 1'b1, 4'd6, 1'b0, 3'd1);
      w_flush = 1'b1;
      tick();
      w_flush = 1'b0;
      check_out("stall.flush", 1'b1, 1'b0, 4'd6, 1'b0, 3'd1);
      tick();

      // Async reset mid-batch, between clock edges.
      push(4'd9);
      push(4'd9);
      check_out("prerst", 1'b0, 1'b1, exp_99_sum, 1'b1, 3'd2);
      #2;
      w_rst = 1'b1;
      #1;
      check_out("async_rst", 1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
      #1;
      w_rst = 1'b0;
      tick();
      check_out("postrst", 1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
      push(4'd2);
      push(4'd2);
      push(4'd2);
      push(4'd2);
      check_out("b2.done", 1'b1, 1'b0, 4'd8, 1'b0, 3'd4);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
